// File: rtl/micro_sequencer_if.sv
// Control-register and status bundle between the ARMSIM control unit and its
// microstate sequencer.
interface micro_sequencer_if;
  logic [6:0] enc_state;
  logic [2:0] cr_sel;
  logic [6:0] cr_target;
  logic [1:0] cr_test;
  logic       moc;
  logic       cond_true;
  logic [6:0] state;
  logic       stall;
  logic       timeout;
  logic       err;
  logic [1:0] depth;

  modport master (
    output enc_state, cr_sel, cr_target, cr_test, moc, cond_true,
    input  state, stall, timeout, err, depth
  );

  modport slave (
    input  enc_state, cr_sel, cr_target, cr_test, moc, cond_true,
    output state, stall, timeout, err, depth
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microstate next-address engine: decode/inc/jump/call/return sources, a
// 2-deep return stack and a MOC wait handshake with timeout abort.
module micro_sequencer #(
  parameter logic [6:0] FETCH_STATE = 7'd1,
  parameter logic [6:0] UNDEF_CODE  = 7'd91,
  parameter logic [6:0] UNDEF_STATE = 7'd92,
  parameter logic [6:0] ABORT_STATE = 7'd93,
  parameter int         TIMEOUT     = 15
) (
  input logic               Clk,
  input logic               Clr,
  micro_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    SEL_FETCH  = 3'b000,
    SEL_DECODE = 3'b001,
    SEL_INC    = 3'b010,
    SEL_JUMP   = 3'b011,
    SEL_CJUMP  = 3'b100,
    SEL_WAIT   = 3'b101,
    SEL_CALL   = 3'b110,
    SEL_RET    = 3'b111
  } selT;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  selT        sel;
  logic [6:0] stateQ, stateNext, incState;
  logic [6:0] stackLo, stackHi, stackTop;
  logic [1:0] depthQ, depthNext;
  logic [7:0] waitCount;
  logic       testBit, waitMiss, abortNow, pushEn, errSet;
  logic       timeoutQ, errQ;

  assign sel      = selT'(bus.cr_sel);
  assign incState = stateQ + 7'd1;
  // Entries fill bottom-up, so the top is the high slot only when full.
  assign stackTop = (depthQ == 2'd2) ? stackHi : stackLo;
  assign waitMiss = (sel == SEL_WAIT) && !testBit;
  assign abortNow = waitMiss && (waitCount == WAIT_LAST);

  always_comb begin
    case (bus.cr_test)
      2'b00:   testBit = bus.moc;
      2'b01:   testBit = bus.cond_true;
      2'b10:   testBit = !bus.moc;
      default: testBit = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      stateQ    <= 7'd0;
      depthQ    <= 2'd0;
      stackLo   <= 7'd0;
      stackHi   <= 7'd0;
      waitCount <= 8'd0;
      timeoutQ  <= 1'b0;
      errQ      <= 1'b0;
    end else begin
      stateQ    <= stateNext;
      depthQ    <= depthNext;
      timeoutQ  <= abortNow;
      errQ      <= errQ | errSet;
      waitCount <= (waitMiss && !abortNow) ? waitCount + 8'd1 : 8'd0;
      if (pushEn) begin
        if (depthQ == 2'd0) stackLo <= incState;
        else                stackHi <= incState;
      end
    end
  end

  always_comb begin
    stateNext = stateQ;
    depthNext = depthQ;
    pushEn    = 1'b0;
    errSet    = 1'b0;
    case (sel)
      SEL_FETCH:  stateNext = FETCH_STATE;
      SEL_DECODE: begin
        if (bus.enc_state == 7'd0)            stateNext = FETCH_STATE;
        else if (bus.enc_state == UNDEF_CODE) stateNext = UNDEF_STATE;
        else                                  stateNext = bus.enc_state;
      end
      SEL_INC:    stateNext = incState;
      SEL_JUMP:   stateNext = bus.cr_target;
      SEL_CJUMP:  stateNext = testBit ? bus.cr_target : incState;
      SEL_WAIT: begin
        if (testBit)       stateNext = incState;
        else if (abortNow) stateNext = ABORT_STATE;
        else               stateNext = stateQ;
      end
      SEL_CALL: begin
        stateNext = bus.cr_target;
        // A full stack drops the return address but still takes the jump.
        if (depthQ != 2'd2) begin
          pushEn    = 1'b1;
          depthNext = depthQ + 2'd1;
        end else begin
          errSet = 1'b1;
        end
      end
      SEL_RET: begin
        if (depthQ == 2'd0) begin
          stateNext = FETCH_STATE;
          errSet    = 1'b1;
        end else begin
          stateNext = stackTop;
          depthNext = depthQ - 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    bus.stall   = waitMiss & Clr;
    bus.state   = stateQ;
    bus.depth   = depthQ;
    bus.timeout = timeoutQ;
    bus.err     = errQ;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed vector table, hand-built wait/timeout
// and reset sequences, then random control words against a reference model.
module tb_micro_sequencer;
  localparam int TIMEOUT = 15;

  logic Clk;
  logic Clr;
  int   checks = 0;
  int   errors = 0;

  micro_sequencer_if bus();

  micro_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference model: plain integers and a queue for the return stack.
  int mState;
  int mStack[$];
  int mWait;
  bit mErr;
  bit mTimeout;

  typedef struct {
    int sel;
    int test;
    int target;
    int enc;
    int mocV;
    int condV;
    int expState;
    int expDepth;
    int expErr;
  } vecT;

  vecT vecs[20];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit testBitOf(input int test, input int mocV, input int condV);
    case (test)
      0:       return mocV != 0;
      1:       return condV != 0;
      2:       return mocV == 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic modelReset();
    mState   = 0;
    mStack   = {};
    mWait    = 0;
    mErr     = 0;
    mTimeout = 0;
  endtask

  task automatic modelStep(input int sel, input int test, input int target,
                           input int enc, input int mocV, input int condV);
    bit t;
    int n;
    t        = testBitOf(test, mocV, condV);
    mTimeout = 0;
    n        = mState;
    case (sel)
      0: n = 1;
      1: n = (enc == 0) ? 1 : (enc == 91) ? 92 : enc;
      2: n = (mState + 1) % 128;
      3: n = target;
      4: n = t ? target : (mState + 1) % 128;
      5: begin
        if (t) begin
          n = (mState + 1) % 128;
        end else begin
          mWait++;
          if (mWait == TIMEOUT) begin
            n        = 93;
            mTimeout = 1;
            mWait    = 0;
          end
        end
      end
      6: begin
        if (mStack.size() < 2) mStack.push_back((mState + 1) % 128);
        else                   mErr = 1;
        n = target;
      end
      default: begin
        if (mStack.size() == 0) begin
          n    = 1;
          mErr = 1;
        end else begin
          n = mStack.pop_back();
        end
      end
    endcase
    if (!(sel == 5 && !t)) mWait = 0;
    mState = n;
  endtask

  task automatic checkOutput();
    check("state",   int'(bus.state),   mState);
    check("depth",   int'(bus.depth),   mStack.size());
    check("err",     int'(bus.err),     int'(mErr));
    check("timeout", int'(bus.timeout), int'(mTimeout));
  endtask

  // Drives one control word a cycle ahead of the edge, checks the zero-latency
  // stall, then checks registered outputs just after the edge.
  task automatic applyStimulus(input int sel, input int test, input int target,
                               input int enc, input int mocV, input int condV);
    bus.cr_sel    = 3'(sel);
    bus.cr_test   = 2'(test);
    bus.cr_target = 7'(target);
    bus.enc_state = 7'(enc);
    bus.moc       = 1'(mocV);
    bus.cond_true = 1'(condV);
    #1;
    check("stall", int'(bus.stall), int'(sel == 5 && !testBitOf(test, mocV, condV)));
    modelStep(sel, test, target, enc, mocV, condV);
    @(posedge Clk);
    #1;
    checkOutput();
  endtask

  task automatic applyReset();
    Clr = 1'b0;
    #1;
    check("rstState", int'(bus.state), 0);
    check("rstDepth", int'(bus.depth), 0);
    check("rstErr",   int'(bus.err),   0);
    check("rstStall", int'(bus.stall), 0);
    @(posedge Clk);
    #1;
    Clr = 1'b1;
    modelReset();
  endtask

  initial begin
    int sel, test;
    bus.cr_sel    = 3'd5;
    bus.cr_test   = 2'd0;
    bus.cr_target = 7'd0;
    bus.enc_state = 7'd0;
    bus.moc       = 1'b0;
    bus.cond_true = 1'b0;
    modelReset();
    applyReset();

    vecs[0]  = '{1, 0, 0,   44, 0, 0, 44,  0, 0};
    vecs[1]  = '{1, 0, 0,   91, 0, 0, 92,  0, 0};
    vecs[2]  = '{1, 0, 0,   0,  0, 0, 1,   0, 0};
    vecs[3]  = '{3, 0, 30,  0,  0, 0, 30,  0, 0};
    vecs[4]  = '{4, 1, 50,  0,  0, 1, 50,  0, 0};
    vecs[5]  = '{3, 0, 30,  0,  0, 0, 30,  0, 0};
    vecs[6]  = '{4, 1, 50,  0,  0, 0, 31,  0, 0};
    vecs[7]  = '{3, 0, 10,  0,  0, 0, 10,  0, 0};
    vecs[8]  = '{6, 0, 60,  0,  0, 0, 60,  1, 0};
    vecs[9]  = '{6, 0, 70,  0,  0, 0, 70,  2, 0};
    vecs[10] = '{6, 0, 80,  0,  0, 0, 80,  2, 1};
    vecs[11] = '{7, 0, 0,   0,  0, 0, 61,  1, 1};
    vecs[12] = '{7, 0, 0,   0,  0, 0, 11,  0, 1};
    vecs[13] = '{7, 0, 0,   0,  0, 0, 1,   0, 1};
    vecs[14] = '{3, 0, 127, 0,  0, 0, 127, 0, 1};
    vecs[15] = '{2, 0, 0,   0,  0, 0, 0,   0, 1};
    vecs[16] = '{3, 0, 127, 0,  0, 0, 127, 0, 1};
    vecs[17] = '{6, 0, 5,   0,  0, 0, 5,   1, 1};
    vecs[18] = '{7, 0, 0,   0,  0, 0, 0,   0, 1};
    vecs[19] = '{0, 0, 0,   0,  0, 0, 1,   0, 1};

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].test, vecs[i].target,
                    vecs[i].enc, vecs[i].mocV, vecs[i].condV);
      check($sformatf("vec%0dState", i), int'(bus.state), vecs[i].expState);
      check($sformatf("vec%0dDepth", i), int'(bus.depth), vecs[i].expDepth);
      check($sformatf("vec%0dErr",   i), int'(bus.err),   vecs[i].expErr);
    end

    // MOC arrives on the fourth wait cycle.
    applyStimulus(3, 0, 20, 0, 0, 0);
    repeat (3) begin
      applyStimulus(5, 0, 0, 0, 0, 0);
      check("waitHold", int'(bus.state), 20);
    end
    applyStimulus(5, 0, 0, 0, 1, 0);
    check("waitAdvance", int'(bus.state), 21);
    check("waitNoTimeout", int'(bus.timeout), 0);

    // Full timeout, then confirm the counter restarted from zero.
    applyStimulus(3, 0, 20, 0, 0, 0);
    repeat (TIMEOUT) applyStimulus(5, 0, 0, 0, 0, 0);
    check("abortState", int'(bus.state), 93);
    check("abortPulse", int'(bus.timeout), 1);
    repeat (TIMEOUT - 1) applyStimulus(5, 0, 0, 0, 0, 0);
    check("abortRestartState", int'(bus.state), 93);
    check("abortRestartPulse", int'(bus.timeout), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    check("pulseOneCycle", int'(bus.timeout), 0);

    // MOC on the last allowed cycle rescues the wait.
    applyStimulus(3, 0, 20, 0, 0, 0);
    repeat (TIMEOUT - 1) applyStimulus(5, 0, 0, 0, 0, 0);
    applyStimulus(5, 0, 0, 0, 1, 0);
    check("lateMocState", int'(bus.state), 21);
    check("lateMocTimeout", int'(bus.timeout), 0);

    // Asynchronous reset in the middle of a call.
    applyStimulus(6, 0, 40, 0, 0, 0);
    #2;
    Clr = 1'b0;
    #1;
    check("midRstState", int'(bus.state), 0);
    check("midRstDepth", int'(bus.depth), 0);
    check("midRstErr",   int'(bus.err),   0);
    bus.cr_sel  = 3'd5;
    bus.cr_test = 2'd0;
    bus.moc     = 1'b0;
    #1;
    check("midRstStall", int'(bus.stall), 0);
    @(posedge Clk);
    #1;
    Clr = 1'b1;
    modelReset();
    applyStimulus(7, 0, 0, 0, 0, 0);
    check("stackClearedRet", int'(bus.state), 1);

    applyReset();
    for (int i = 0; i < 400; i++) begin
      sel  = (i % 100 < 40) ? 5 : int'($urandom_range(0, 7));
      test = (sel == 5 && i % 100 < 40) ? 0 : int'($urandom_range(0, 3));
      applyStimulus(sel, test, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
